// File: rtl/alu_4bit_reg_if.sv
// Operand/opcode and result/flag bundle for the registered 4-bit ALU.
// master drives operands and observes results; slave is the ALU side.
interface alu_4bit_reg_if;
   logic       valid_in;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] ALU_Sel;
   logic [3:0] ALU_Result;
   logic       Zero;
   logic       Carry;
   logic       Overflow;
   logic       valid_out;

   modport master (
      output valid_in, a, b, ALU_Sel,
      input  ALU_Result, Zero, Carry, Overflow, valid_out
   );

   modport slave (
      input  valid_in, a, b, ALU_Sel,
      output ALU_Result, Zero, Carry, Overflow, valid_out
   );
endinterface

// File: rtl/alu_4bit_reg.sv
// Registered 4-bit ALU: eight arithmetic/logic/shift ops, one-cycle latency,
// with Zero/Carry/Overflow flags and a one-cycle valid_out pulse per capture.
module alu_4bit_reg (
   input logic            clk,
   input logic            rst,
   alu_4bit_reg_if.slave  bus
);
   localparam int unsigned W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   logic [W:0]   sum;
   logic [W:0]   diff;
   logic [W-1:0] res_c;
   logic         carry_c;
   logic         ovf_c;

   assign sum  = (W+1)'(bus.a) + (W+1)'(bus.b);
   // diff[W] doubles as the unsigned borrow (a < b)
   assign diff = (W+1)'(bus.a) - (W+1)'(bus.b);

   // Next result and flags for the current opcode
   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      unique case (op_e'(bus.ALU_Sel))
         OP_ADD: begin
            res_c   = sum[W-1:0];
            carry_c = sum[W];
            ovf_c   = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
         end
         OP_SUB: begin
            res_c   = diff[W-1:0];
            carry_c = diff[W];
            ovf_c   = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
         end
         OP_AND: res_c = bus.a & bus.b;
         OP_OR:  res_c = bus.a | bus.b;
         OP_XOR: res_c = bus.a ^ bus.b;
         OP_NOT: res_c = ~bus.a;
         OP_SHL: begin
            res_c   = {bus.a[W-2:0], 1'b0};
            carry_c = bus.a[W-1];
         end
         OP_SHR: begin
            res_c   = {1'b0, bus.a[W-1:1]};
            carry_c = bus.a[0];
         end
         default: res_c = '0;
      endcase
   end

   // Output registers; Zero resets high so it always agrees with ALU_Result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ALU_Result <= '0;
         bus.Zero       <= 1'b1;
         bus.Carry      <= 1'b0;
         bus.Overflow   <= 1'b0;
         bus.valid_out  <= 1'b0;
      end else begin
         bus.valid_out <= bus.valid_in;
         if (bus.valid_in) begin
            bus.ALU_Result <= res_c;
            bus.Zero       <= (res_c == '0);
            bus.Carry      <= carry_c;
            bus.Overflow   <= ovf_c;
         end
      end
   end
endmodule

// File: tb/tb_alu_4bit_reg.sv
// Directed-vector bench for alu_4bit_reg; expectations are hand-computed
// and packed as {valid_out, Zero, Carry, Overflow, ALU_Result}.
module tb_alu_4bit_reg;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   alu_4bit_reg_if bus ();

   alu_4bit_reg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pack_exp(input logic v, input logic z,
                                           input logic c, input logic o,
                                           input logic [3:0] r);
      return {v, z, c, o, r};
   endfunction

   function automatic logic [7:0] observed();
      return {bus.valid_out, bus.Zero, bus.Carry, bus.Overflow, bus.ALU_Result};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got v/z/c/o/r=%b/%b/%b/%b/%h want %b/%b/%b/%b/%h", tag,
                  got[7], got[6], got[5], got[4], got[3:0],
                  want[7], want[6], want[5], want[4], want[3:0]);
      end
   endtask

   // Present one captured operation and sample just after the capturing edge
   task automatic op(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] sel);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.a        = ta;
      bus.b        = tb;
      bus.ALU_Sel  = sel;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] sel);
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.a        = ta;
      bus.b        = tb;
      bus.ALU_Sel  = sel;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst          = 1'b1;
      bus.valid_in = 1'b0;
      bus.a        = 4'd0;
      bus.b        = 4'd0;
      bus.ALU_Sel  = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", observed(), pack_exp(0, 1, 0, 0, 4'h0));
      @(negedge clk);
      rst = 1'b0;

      op(4'd7,  4'd1, 3'b000); check("add_7_1",   observed(), pack_exp(1, 0, 0, 1, 4'd8));
      op(4'd15, 4'd1, 3'b000); check("add_15_1",  observed(), pack_exp(1, 1, 1, 0, 4'd0));
      op(4'd3,  4'd5, 3'b001); check("sub_3_5",   observed(), pack_exp(1, 0, 1, 0, 4'd14));
      op(4'd8,  4'd1, 3'b001); check("sub_8_1",   observed(), pack_exp(1, 0, 0, 1, 4'd7));
      op(4'd5,  4'd5, 3'b001); check("sub_5_5",   observed(), pack_exp(1, 1, 0, 0, 4'd0));
      op(4'b1100, 4'b1010, 3'b010); check("and",  observed(), pack_exp(1, 0, 0, 0, 4'b1000));
      op(4'b1100, 4'b1010, 3'b011); check("or",   observed(), pack_exp(1, 0, 0, 0, 4'b1110));
      op(4'b1100, 4'b1010, 3'b100); check("xor",  observed(), pack_exp(1, 0, 0, 0, 4'b0110));
      op(4'b1111, 4'b0101, 3'b101); check("not",  observed(), pack_exp(1, 1, 0, 0, 4'b0000));
      op(4'b1001, 4'b0000, 3'b110); check("shl",  observed(), pack_exp(1, 0, 1, 0, 4'b0010));
      op(4'b1001, 4'b0000, 3'b111); check("shr_1001", observed(), pack_exp(1, 0, 1, 0, 4'b0100));
      op(4'b0110, 4'b0000, 3'b111); check("shr_0110", observed(), pack_exp(1, 0, 0, 0, 4'b0011));

      // Hold: results and flags freeze while valid_in is low
      op(4'd2, 4'd3, 3'b000); check("hold_cap", observed(), pack_exp(1, 0, 0, 0, 4'd5));
      idle(4'd15, 4'd1, 3'b000); check("hold_1", observed(), pack_exp(0, 0, 0, 0, 4'd5));
      idle(4'd3,  4'd5, 3'b001); check("hold_2", observed(), pack_exp(0, 0, 0, 0, 4'd5));
      idle(4'd9,  4'd0, 3'b110); check("hold_3", observed(), pack_exp(0, 0, 0, 0, 4'd5));

      // Back-to-back sweep of all opcodes on a=1100, b=1010
      op(4'b1100, 4'b1010, 3'b000); check("sw_add", observed(), pack_exp(1, 0, 1, 1, 4'b0110));
      op(4'b1100, 4'b1010, 3'b001); check("sw_sub", observed(), pack_exp(1, 0, 0, 0, 4'b0010));
      op(4'b1100, 4'b1010, 3'b010); check("sw_and", observed(), pack_exp(1, 0, 0, 0, 4'b1000));
      op(4'b1100, 4'b1010, 3'b011); check("sw_or",  observed(), pack_exp(1, 0, 0, 0, 4'b1110));
      op(4'b1100, 4'b1010, 3'b100); check("sw_xor", observed(), pack_exp(1, 0, 0, 0, 4'b0110));
      op(4'b1100, 4'b1010, 3'b101); check("sw_not", observed(), pack_exp(1, 0, 0, 0, 4'b0011));
      op(4'b1100, 4'b1010, 3'b110); check("sw_shl", observed(), pack_exp(1, 0, 1, 0, 4'b1000));
      op(4'b1100, 4'b1010, 3'b111); check("sw_shr", observed(), pack_exp(1, 0, 0, 0, 4'b0110));

      // Asynchronous reset between edges with a capture pending
      op(4'd7, 4'd1, 3'b000); check("pre_rst", observed(), pack_exp(1, 0, 0, 1, 4'd8));
      #1;
      rst = 1'b1;
      #1;
      check("async_rst", observed(), pack_exp(0, 1, 0, 0, 4'd0));
      @(posedge clk);
      #1;
      check("rst_held", observed(), pack_exp(0, 1, 0, 0, 4'd0));
      @(negedge clk);
      rst = 1'b0;
      bus.valid_in = 1'b1;
      bus.a        = 4'd2;
      bus.b        = 4'd3;
      bus.ALU_Sel  = 3'b000;
      @(posedge clk);
      #1;
      check("post_rst", observed(), pack_exp(1, 0, 0, 0, 4'd5));
      idle(4'd0, 4'd0, 3'b000); check("post_idle", observed(), pack_exp(0, 0, 0, 0, 4'd5));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_4bit_reg.md
Name: alu_4bit_reg

Overview:
Registered 4-bit ALU. It performs 8 operations (arithmetic, logic, shift) on two 4-bit operands and produces a 4-bit result plus Zero, Carry and Overflow flags. Operands and opcode are sampled on the rising clock edge, and the result and flags appear one cycle later. It sits in small datapaths as a single-cycle execute stage with a simple valid qualifier.

Parameters:
None. Width is fixed at 4 bits and opcode width at 3 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
valid_in  input  1  qualifies a, b, ALU_Sel for capture this cycle
a  input  4  operand A (unsigned or two's complement, depending on the flag)
b  input  4  operand B
ALU_Sel  input  3  opcode
ALU_Result  output  4  registered result
Zero  output  1  registered; 1 iff ALU_Result == 4'b0000
Carry  output  1  registered carry/borrow/shift-out flag
Overflow  output  1  registered signed-overflow flag
valid_out  output  1  1 for exactly one cycle after each captured valid_in

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. It takes effect immediately, independent of clk.
- Reset values: ALU_Result=0, Carry=0, Overflow=0, valid_out=0, Zero=1. Zero therefore stays consistent with the result at all times.
- Latency is 1 cycle. When valid_in=1 at posedge N, the outputs at posedge N reflect a/b/ALU_Sel sampled at N. valid_out=1 during the following cycle.
- When valid_in=0 at a posedge: ALU_Result, Zero, Carry and Overflow hold their previous values, and valid_out goes to 0.
- Opcodes (R = result, all 4-bit, wrap modulo 16):
  - 000 ADD: R=a+b. Carry=bit 4 of the 5-bit sum. Overflow=1 iff a[3]==b[3] and R[3]!=a[3].
  - 001 SUB: R=a-b. Carry=borrow, i.e. 1 iff a<b unsigned. Overflow=1 iff a[3]!=b[3] and R[3]!=a[3].
  - 010 AND: R=a&b. Carry=0, Overflow=0.
  - 011 OR: R=a|b. Carry=0, Overflow=0.
  - 100 XOR: R=a^b. Carry=0, Overflow=0.
  - 101 NOT: R=~a (b ignored). Carry=0, Overflow=0.
  - 110 SHL: R={a[2:0],1'b0}. Carry=a[3] (bit shifted out). Overflow=0.
  - 111 SHR (logical): R={1'b0,a[3:1]}. Carry=a[0]. Overflow=0.
- Zero is computed from the new R in the same cycle the result is registered. Zero==(ALU_Result==0) holds in every cycle, including during and after reset.
- Overflow is nonzero only for opcodes 000 and 001.
- Reset asserted mid-operation: the pending capture is discarded and outputs go to their reset values. The first capture after release occurs at the first posedge with rst=0 and valid_in=1.
- Unknown or X opcode is not a legal input. All 8 codes are defined, so there is no illegal opcode.
- Implementation: combinational next-state logic feeding output registers. No internal pipelining beyond the single stage.

Test Plan:
- Reset: assert rst asynchronously between edges -> outputs become R=0, Zero=1, Carry=0, Overflow=0, valid_out=0 immediately, without waiting for a clock edge.
- ADD: a=7,b=1,sel=000 -> next cycle R=8, Carry=0, Overflow=1, Zero=0. Then a=15,b=1 -> R=0, Carry=1, Overflow=0, Zero=1.
- SUB: a=3,b=5,sel=001 -> R=14, Carry=1, Overflow=0. Then a=8,b=1 -> R=7, Carry=0, Overflow=1. Then a=5,b=5 -> R=0, Zero=1.
- Logic: a=1100,b=1010 -> AND=1000, OR=1110, XOR=0110. NOT with a=1111 -> R=0, Zero=1. Carry and Overflow stay 0 throughout.
- Shifts: a=1001 with SHL -> R=0010, Carry=1. a=1001 with SHR -> R=0100, Carry=1. a=0110 with SHR -> R=0011, Carry=0.
- Hold/valid: capture ADD 2+3, then drive valid_in=0 with changing a/b/sel for 3 cycles -> R stays 5 with flags unchanged, and valid_out is 1 for one cycle only. Sweep all 8 opcodes back-to-back with valid_in=1 -> each result appears exactly one cycle after its inputs.
